// File: rtl/neighbor_gen_if.sv
// Handshake bundle for neighbor_gen: expansion request, wall-map read port and neighbour offer.
// The master modport is the generator's view; slave is the environment (wall map, open-list stage).
interface neighbor_gen_if;
    logic       start;
    logic [7:0] cur_x;
    logic [7:0] cur_y;
    logic       busy;
    logic       wall_rd_en;
    logic [8:0] wall_addr;
    logic       wall_q;
    logic       nb_valid;
    logic       nb_ready;
    logic [7:0] nb_x;
    logic [7:0] nb_y;
    logic [2:0] nb_dir;
    logic       done;
    logic [3:0] nb_count;

    modport master (
        input  start, cur_x, cur_y, wall_q, nb_ready,
        output busy, wall_rd_en, wall_addr, nb_valid, nb_x, nb_y, nb_dir, done, nb_count
    );

    modport slave (
        output start, cur_x, cur_y, wall_q, nb_ready,
        input  busy, wall_rd_en, wall_addr, nb_valid, nb_x, nb_y, nb_dir, done, nb_count
    );
endinterface

// File: rtl/neighbor_gen.sv
// Grid neighbour generator: walks the 4 (or 8 with NEIGHBOR_DIAGONAL_EN) neighbours of a node,
// skips out-of-bounds and walled candidates, and offers the rest over a valid/ready handshake.
//
// state    | meaning
// IDLE     | waiting for start
// GEN      | candidate chosen; wall read issued if in bounds, else skipped
// WALL_CHK | wall bit returned; blocked candidates are skipped
// EMIT     | offer held on nb_* until nb_ready
// DONE     | one-cycle done pulse
module neighbor_gen #(
    parameter int GRID_W = 20,
    parameter int GRID_H = 20
) (
    input  logic          Clk,
    input  logic          Reset,
    neighbor_gen_if.master bus
);

`ifdef NEIGHBOR_DIAGONAL_EN
    localparam logic [2:0] LAST_DIR = 3'd7;
`else
    localparam logic [2:0] LAST_DIR = 3'd3;
`endif

    typedef enum logic [2:0] {IDLE, GEN, WALL_CHK, EMIT, DONE} state_t;

    typedef struct packed {
        logic       inb;
        logic [7:0] x;
        logic [7:0] y;
        logic [8:0] addr;
    } cand_t;

    // Signed arithmetic so that x-1 / y-1 at the edge is seen as negative rather than wrapping.
    function automatic cand_t make_cand(input logic [2:0] d, input logic [7:0] px,
                                        input logic [7:0] py);
        cand_t c;
        int    dx;
        int    dy;
        int    cx;
        int    cy;
        int    lin;
        dx = 0;
        dy = 0;
        case (d)
            3'd0:    dy = -1;
            3'd1:    dx = 1;
            3'd2:    dy = 1;
            3'd3:    dx = -1;
            3'd4:    begin dx = 1;  dy = -1; end
            3'd5:    begin dx = 1;  dy = 1;  end
            3'd6:    begin dx = -1; dy = 1;  end
            default: begin dx = -1; dy = -1; end
        endcase
        cx     = int'(px) + dx;
        cy     = int'(py) + dy;
        lin    = cy * GRID_W + cx;
        c.inb  = (int'(px) < GRID_W) && (int'(py) < GRID_H) &&
                 (cx >= 0) && (cx < GRID_W) && (cy >= 0) && (cy < GRID_H);
        c.x    = 8'(cx);
        c.y    = 8'(cy);
        c.addr = 9'(lin);
        return c;
    endfunction

    state_t     state;
    logic [7:0] node_x;
    logic [7:0] node_y;
    logic [2:0] dir;
    logic       cand_inb;
    logic [7:0] cand_x;
    logic [7:0] cand_y;

    logic       busy;
    logic       wall_rd_en;
    logic [8:0] wall_addr;
    logic       nb_valid;
    logic [7:0] nb_x;
    logic [7:0] nb_y;
    logic [2:0] nb_dir;
    logic       done;
    logic [3:0] nb_count;

    cand_t      first_cand;
    cand_t      next_cand;
    logic [2:0] dir_next;
    logic       advance;

    assign dir_next   = dir + 3'd1;
    assign first_cand = make_cand(3'd0, bus.cur_x, bus.cur_y);
    assign next_cand  = make_cand(dir_next, node_x, node_y);

    // Current candidate is finished: skipped (bounds or wall) or accepted downstream.
    always_comb begin
        advance = 1'b0;
        case (state)
            GEN:      advance = !cand_inb;
            WALL_CHK: advance = bus.wall_q;
            EMIT:     advance = bus.nb_ready;
            default:  advance = 1'b0;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            node_x     <= 8'd0;
            node_y     <= 8'd0;
            dir        <= 3'd0;
            cand_inb   <= 1'b0;
            cand_x     <= 8'd0;
            cand_y     <= 8'd0;
            busy       <= 1'b0;
            wall_rd_en <= 1'b0;
            wall_addr  <= 9'd0;
            nb_valid   <= 1'b0;
            nb_x       <= 8'd0;
            nb_y       <= 8'd0;
            nb_dir     <= 3'd0;
            done       <= 1'b0;
            nb_count   <= 4'd0;
        end else begin
            wall_rd_en <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        node_x     <= bus.cur_x;
                        node_y     <= bus.cur_y;
                        dir        <= 3'd0;
                        nb_count   <= 4'd0;
                        cand_inb   <= first_cand.inb;
                        cand_x     <= first_cand.x;
                        cand_y     <= first_cand.y;
                        wall_rd_en <= first_cand.inb;
                        if (first_cand.inb) wall_addr <= first_cand.addr;
                        busy       <= 1'b1;
                        state      <= GEN;
                    end
                end
                GEN: begin
                    if (cand_inb) state <= WALL_CHK;
                end
                WALL_CHK: begin
                    if (!bus.wall_q) begin
                        nb_valid <= 1'b1;
                        nb_x     <= cand_x;
                        nb_y     <= cand_y;
                        nb_dir   <= dir;
                        state    <= EMIT;
                    end
                end
                EMIT: begin
                    if (bus.nb_ready) begin
                        nb_valid <= 1'b0;
                        nb_count <= nb_count + 4'd1;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (advance) begin
                if (dir == LAST_DIR) begin
                    done  <= 1'b1;
                    state <= DONE;
                end else begin
                    dir        <= dir_next;
                    cand_inb   <= next_cand.inb;
                    cand_x     <= next_cand.x;
                    cand_y     <= next_cand.y;
                    wall_rd_en <= next_cand.inb;
                    if (next_cand.inb) wall_addr <= next_cand.addr;
                    state      <= GEN;
                end
            end
        end
    end

    assign bus.busy       = busy;
    assign bus.wall_rd_en = wall_rd_en;
    assign bus.wall_addr  = wall_addr;
    assign bus.nb_valid   = nb_valid;
    assign bus.nb_x       = nb_x;
    assign bus.nb_y       = nb_y;
    assign bus.nb_dir     = nb_dir;
    assign bus.done       = done;
    assign bus.nb_count   = nb_count;

endmodule

// File: tb/tb_neighbor_gen.sv
// Scoreboard bench for neighbor_gen: stimulus pushes expected wall reads, offers and done counts;
// a negedge monitor pops and compares whatever the DUT presents.
module tb_neighbor_gen;
    logic Clk = 1'b0;
    logic Reset = 1'b0;
    always #5 Clk = ~Clk;

    neighbor_gen_if bus ();

    neighbor_gen #(.GRID_W(20), .GRID_H(20)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        int x;
        int y;
        int dir;
    } offer_t;

    offer_t exp_off[$];
    int     exp_rd[$];
    int     exp_done[$];

    int errors = 0;
    int checks = 0;
    int acc_cnt = 0;

    logic wall_map [0:511];

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) bus.wall_q <= 1'b0;
        else        bus.wall_q <= bus.wall_rd_en ? wall_map[bus.wall_addr] : 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input int val);
        checks++;
        errors++;
        $display("FAIL %s: got %0d with nothing expected", name, val);
    endtask

    // Monitor
    logic       hold_pending = 1'b0;
    logic [7:0] hold_x;
    logic [7:0] hold_y;
    logic [2:0] hold_dir;
    logic       prev_done = 1'b0;

    always @(negedge Clk) begin
        if (Reset) begin
            if (bus.wall_rd_en) begin
                if (exp_rd.size() == 0) unexpected("wall_rd", int'(bus.wall_addr));
                else check("wall_addr", 32'(bus.wall_addr), 32'(exp_rd.pop_front()));
            end
            if (hold_pending) begin
                check("hold_valid", 32'(bus.nb_valid), 32'd1);
                check("hold_xy", {16'd0, bus.nb_x, bus.nb_y}, {16'd0, hold_x, hold_y});
                check("hold_dir", 32'(bus.nb_dir), 32'(hold_dir));
            end
            if (bus.nb_valid && bus.nb_ready) begin
                if (exp_off.size() == 0) unexpected("offer", int'(bus.nb_dir));
                else begin
                    offer_t o;
                    o = exp_off.pop_front();
                    check("offer_x", 32'(bus.nb_x), 32'(o.x));
                    check("offer_y", 32'(bus.nb_y), 32'(o.y));
                    check("offer_dir", 32'(bus.nb_dir), 32'(o.dir));
                end
                acc_cnt++;
            end
            if (bus.done) begin
                if (prev_done) unexpected("done_wide", 1);
                if (exp_done.size() == 0) unexpected("done", int'(bus.nb_count));
                else check("done_nb_count", 32'(bus.nb_count), 32'(exp_done.pop_front()));
            end
            hold_pending = bus.nb_valid && !bus.nb_ready;
            hold_x       = bus.nb_x;
            hold_y       = bus.nb_y;
            hold_dir     = bus.nb_dir;
            prev_done    = bus.done;
        end else begin
            hold_pending = 1'b0;
            prev_done    = 1'b0;
        end
    end

    task automatic push_off(input int x, input int y, input int d);
        offer_t o;
        o.x = x;
        o.y = y;
        o.dir = d;
        exp_off.push_back(o);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_wall_rd_en"}, 32'(bus.wall_rd_en), 32'd0);
        check({tag, "_wall_addr"}, 32'(bus.wall_addr), 32'd0);
        check({tag, "_nb_valid"}, 32'(bus.nb_valid), 32'd0);
        check({tag, "_nb_xy"}, {16'd0, bus.nb_x, bus.nb_y}, 32'd0);
        check({tag, "_nb_dir"}, 32'(bus.nb_dir), 32'd0);
        check({tag, "_done"}, 32'(bus.done), 32'd0);
        check({tag, "_nb_count"}, 32'(bus.nb_count), 32'd0);
    endtask

    // Runs one expansion; edges are counted from the start edge to the edge that raises done.
    task automatic expand(input string tag, input int x, input int y, input int exp_edges,
                          input int exp_cnt, input int stall_n, input bit restart);
        int n;
        int stalled;
        bit got;
        exp_done.push_back(exp_cnt);
        @(negedge Clk);
        bus.cur_x = 8'(x);
        bus.cur_y = 8'(y);
        bus.start = 1'b1;
        @(posedge Clk);
        #1 bus.start = 1'b0;
        n = 0;
        stalled = 0;
        got = 1'b0;
        while (n < 100 && !got) begin
            @(posedge Clk);
            n++;
            #1;
            if (restart && n == 3) begin
                bus.start = 1'b1;
                bus.cur_x = 8'd9;
                bus.cur_y = 8'd9;
            end else if (restart && n == 4) begin
                bus.start = 1'b0;
            end
            if (bus.nb_valid && stalled < stall_n) begin
                bus.nb_ready = 1'b0;
                stalled++;
            end else begin
                bus.nb_ready = 1'b1;
            end
            if (bus.done) got = 1'b1;
        end
        check({tag, "_done_edges"}, got ? 32'(n) : 32'hFFFF_FFFF, 32'(exp_edges));
        @(posedge Clk);
        #1;
        check({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
        check({tag, "_count_hold"}, 32'(bus.nb_count), 32'(exp_cnt));
        check({tag, "_left"}, 32'(exp_off.size() + exp_rd.size() + exp_done.size()), 32'd0);
        exp_off.delete();
        exp_rd.delete();
        exp_done.delete();
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.cur_x    = 8'd0;
        bus.cur_y    = 8'd0;
        bus.nb_ready = 1'b1;
        for (int i = 0; i < 512; i++) wall_map[i] = 1'b0;
        repeat (2) @(posedge Clk);
        #1 check_zero_outputs("reset");
        Reset = 1'b1;
        repeat (2) @(posedge Clk);

`ifndef NEIGHBOR_DIAGONAL_EN
        // Centre node, no walls
        exp_rd = '{85, 106, 125, 104};
        push_off(5, 4, 0); push_off(6, 5, 1); push_off(5, 6, 2); push_off(4, 5, 3);
        expand("center", 5, 5, 12, 4, 0, 1'b0);

        // Corner (0,0): N and W out of bounds, no reads
        exp_rd = '{1, 20};
        push_off(1, 0, 1); push_off(0, 1, 2);
        expand("corner00", 0, 0, 8, 2, 0, 1'b0);

        // Far corner: E and S would be 399+1 / beyond the map
        exp_rd = '{379, 398};
        push_off(19, 18, 0); push_off(18, 19, 3);
        expand("corner1919", 19, 19, 8, 2, 0, 1'b0);

        // Wall on E neighbour, first offer stalled 5 cycles
        wall_map[106] = 1'b1;
        exp_rd = '{85, 106, 125, 104};
        push_off(5, 4, 0); push_off(5, 6, 2); push_off(4, 5, 3);
        expand("stall_wall", 5, 5, 16, 3, 5, 1'b0);
        wall_map[106] = 1'b0;

        // Start re-pulsed mid-expansion with other coordinates
        exp_rd = '{85, 106, 125, 104};
        push_off(5, 4, 0); push_off(6, 5, 1); push_off(5, 6, 2); push_off(4, 5, 3);
        expand("restart", 5, 5, 12, 4, 0, 1'b1);

        // Node itself out of bounds: every direction skipped
        expand("oob_node", 20, 3, 4, 0, 0, 1'b0);
`else
        exp_rd = '{85, 106, 125, 104, 86, 126, 124, 84};
        push_off(5, 4, 0); push_off(6, 5, 1); push_off(5, 6, 2); push_off(4, 5, 3);
        push_off(6, 4, 4); push_off(6, 6, 5); push_off(4, 6, 6); push_off(4, 4, 7);
        expand("diag", 5, 5, 24, 8, 0, 1'b0);

        // Reset while the third offer is on the bus
        begin
            int n;
            bit hit;
            exp_rd = '{85, 106, 125};
            push_off(5, 4, 0); push_off(6, 5, 1);
            acc_cnt = 0;
            @(negedge Clk);
            bus.cur_x = 8'd5;
            bus.cur_y = 8'd5;
            bus.start = 1'b1;
            @(posedge Clk);
            #1 bus.start = 1'b0;
            n = 0;
            hit = 1'b0;
            while (n < 100 && !hit) begin
                @(posedge Clk);
                n++;
                #1;
                if (bus.nb_valid && acc_cnt == 2) hit = 1'b1;
            end
            check("diag_third_offer_seen", 32'(hit), 32'd1);
            Reset = 1'b0;
            #1 check_zero_outputs("diag_rst");
            check("diag_rst_left", 32'(exp_off.size() + exp_rd.size()), 32'd0);
            exp_off.delete();
            exp_rd.delete();
            exp_done.delete();
            repeat (2) @(posedge Clk);
            #1 Reset = 1'b1;
            repeat (10) @(posedge Clk);
            #1 check("diag_idle_after_rst", 32'(bus.busy), 32'd0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/neighbor_gen.md
NEIGHBOR_GEN -- requirements
Module: neighbor_gen

Interface
REQ-001 Parameter GRID_W, default 20: grid width in nodes; GRID_W*GRID_H SHALL be at most 512.
REQ-002 Parameter GRID_H, default 20: grid height in nodes.
REQ-003 Clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 start  input  1  one-cycle request to expand the node at cur_x/cur_y; sampled only in IDLE.
REQ-006 cur_x, cur_y  input  8 each  coordinates of the node being expanded.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 wall_rd_en  output  1  wall-map read strobe.
REQ-009 wall_addr  output  9  wall-map address, y*GRID_W+x of the candidate.
REQ-010 wall_q  input  1  wall bit (1 = blocked), valid the cycle after wall_rd_en.
REQ-011 nb_valid  output  1  neighbour offer to the open-list search stage.
REQ-012 nb_ready  input  1  downstream accepts the offer.
REQ-013 nb_x, nb_y  output  8 each  offered neighbour coordinates.
REQ-014 nb_dir  output  3  direction index of the offered neighbour.
REQ-015 done  output  1  one-cycle pulse marking the end of an expansion.
REQ-016 nb_count  output  4  neighbours accepted in the current/last expansion.

Function
REQ-017 The FSM SHALL have states IDLE, GEN, WALL_CHK, EMIT, DONE.
REQ-018 IDLE: on start=1, latch cur_x/cur_y, clear dir index and nb_count, go to GEN; start is ignored in all other states.
REQ-019 Direction order: 0 N (y-1), 1 E (x+1), 2 S (y+1), 3 W (x-1), plus 4 NE, 5 SE, 6 SW, 7 NW when diagonals are enabled.
REQ-020 GEN: a candidate with any coordinate below 0 or at or above GRID_W/GRID_H SHALL be skipped without a wall read; coordinates never wrap.
REQ-021 GEN, in bounds: drive wall_rd_en=1 and wall_addr for that single cycle, then go to WALL_CHK.
REQ-022 WALL_CHK: wall_q=0 goes to EMIT; wall_q=1 skips the candidate.
REQ-023 EMIT: nb_valid=1 with nb_x/nb_y/nb_dir held stable until the cycle nb_ready=1; on that edge nb_count increments and the candidate advances.
REQ-024 Advance/skip: if dir index is the last direction go to DONE, else increment dir and go to GEN.
REQ-025 DONE: done=1 for exactly one cycle, then IDLE; nb_count holds its value until the next accepted start.
REQ-026 A latched node that is itself out of bounds SHALL skip every direction and produce done with nb_count=0.
REQ-027 nb_ready while nb_valid=0 SHALL have no effect; nb_valid SHALL never drop without acceptance except on reset.
REQ-028 Timing, in-bounds open candidate with nb_ready high: 3 cycles (GEN, WALL_CHK, EMIT); wall-blocked: 2 cycles; out-of-bounds: 1 cycle.

Reset
REQ-029 Reset=0 SHALL asynchronously force IDLE, and clear busy, wall_rd_en, wall_addr, nb_valid, nb_x, nb_y, nb_dir, done and nb_count to 0.
REQ-030 Reset during an expansion SHALL abandon it with no done pulse; operation resumes only on a new start after release.

Configuration
REQ-031 With macro NEIGHBOR_DIAGONAL_EN defined, 8 directions (0-7) SHALL be generated, last direction 7; undefined, only 0-3, last direction 3, and nb_dir[2] is always 0.

Verification
REQ-032 4-dir, start at (5,5), no walls, nb_ready=1: offers (5,4),(6,5),(5,6),(4,5) with dir 0,1,2,3; done asserted after 12th edge following the start edge; nb_count=4.
REQ-033 4-dir, start at (0,0), no walls: only (1,0) dir 1 then (0,1) dir 2; wall_rd_en never for N/W; nb_count=2, done after 8 edges.
REQ-034 Start at (19,19), GRID 20x20: only N (19,18) and W (18,19) offered; no wall read with address >= 400.
REQ-035 Start at (5,5), wall at address 106 (E neighbour), nb_ready held 0 for 5 cycles at first offer: (5,4) held stable with nb_valid=1 throughout, E skipped, nb_count=3.
REQ-036 NEIGHBOR_DIAGONAL_EN, start at (5,5), no walls: 8 offers ending (4,4) dir 7, nb_count=8; Reset=0 during the third offer: all outputs 0 immediately, no done pulse.
REQ-037 Start pulsed again while busy: ignored, the current expansion completes with unchanged coordinates.
